// File: rtl/posit_accum_es3.sv
// posit_accum_es3: streams posit (es=3) terms into four interleaved partial sums around an external
// ADD_LAT-cycle adder, then reduces them to one packet sum. Define POSIT_ACCUM_COUNT_EN to add sum_count.
module posit_accum_es3 #(
   parameter int NBITS   = 32,
   parameter int ADD_LAT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [NBITS-1:0] add_in1,
   output logic [NBITS-1:0] add_in2,
   output logic             add_start,
   input  logic [NBITS-1:0] add_result,
   input  logic             add_done,
   output logic [NBITS-1:0] sum_out,
   output logic             sum_valid,
   input  logic             sum_ready
`ifdef POSIT_ACCUM_COUNT_EN
   ,
   output logic [15:0]      sum_count
`endif
);
   typedef enum logic [2:0] {ACCUM, DRAIN, RED1, RED1_W, RED2, RED2_W, OUT} state_t;
   state_t           state, next;
   logic [NBITS-1:0] p [4];
   logic [1:0]       slot;
   logic             phase;
   logic [ADD_LAT-1:0] tag_v;
   logic [1:0]       tag_t [ADD_LAT];
   logic [NBITS-1:0] a;
   logic [1:0]       b_idx, issue_tag;
   logic             ret, bypass, accept, handshake;

   assign ret       = add_done && tag_v[ADD_LAT-1];
   assign bypass    = ret && tag_t[ADD_LAT-1] == b_idx;
   assign accept    = in_valid && in_ready;
   assign handshake = state == OUT && sum_ready;
   assign add_in1   = add_start ? a : '0;
   assign add_in2   = add_start ? (bypass ? add_result : p[b_idx]) : '0;

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= ACCUM;
      else state <= next;

   // next state, adder issue and operand selection
   always_comb begin
      next      = state;
      in_ready  = 1'b0;
      add_start = 1'b0;
      a         = '0;
      b_idx     = 2'd0;
      issue_tag = 2'd0;
      case (state)
         ACCUM: begin
            in_ready  = 1'b1;
            add_start = in_valid;
            a         = in_data;
            b_idx     = slot;
            issue_tag = slot;
            if (in_valid && in_last) next = DRAIN;
         end
         DRAIN:  if (~|tag_v) next = RED1;
         RED1: begin
            add_start = 1'b1;
            a         = phase ? p[2] : p[0];
            b_idx     = phase ? 2'd3 : 2'd1;
            issue_tag = phase ? 2'd2 : 2'd0;
            if (phase) next = RED1_W;
         end
         RED1_W: if (~|tag_v) next = RED2;
         RED2: begin
            add_start = 1'b1;
            a         = p[0];
            b_idx     = 2'd2;
            next      = RED2_W;
         end
         RED2_W: if (ret) next = OUT;
         OUT:    if (sum_ready) next = ACCUM;
         default: next = ACCUM;
      endcase
   end

   // partial sums, slot pointer, in-flight tags and result register
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < 4; i++) p[i] <= '0;
         for (int i = 0; i < ADD_LAT; i++) tag_t[i] <= '0;
         tag_v     <= '0;
         slot      <= '0;
         phase     <= 1'b0;
         sum_out   <= '0;
         sum_valid <= 1'b0;
      end else begin
         tag_v    <= {tag_v[ADD_LAT-2:0], add_start};
         tag_t[0] <= issue_tag;
         for (int i = 1; i < ADD_LAT; i++) tag_t[i] <= tag_t[i-1];
         if (ret) p[tag_t[ADD_LAT-1]] <= add_result;
         if (accept) slot <= slot + 2'd1;
         if (state == RED1) phase <= ~phase;
         if (state == RED2_W && ret) begin
            sum_out   <= add_result;
            sum_valid <= 1'b1;
         end
         if (handshake) begin
            for (int i = 0; i < 4; i++) p[i] <= '0;
            slot      <= '0;
            sum_valid <= 1'b0;
         end
      end

`ifdef POSIT_ACCUM_COUNT_EN
   // saturating count of terms accepted in the current packet
   always_ff @(posedge clk or posedge reset)
      if (reset) sum_count <= '0;
      else if (handshake) sum_count <= '0;
      else if (accept && sum_count != 16'hFFFF) sum_count <= sum_count + 16'd1;
`endif
endmodule

// File: tb/tb_posit_accum_es3.sv
// tb_posit_accum_es3: directed checks of posit_accum_es3 against a small integer-valued posit adder model.
module tb_posit_accum_es3;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] add_in1, add_in2, add_result, sum_out;
   logic        add_start, add_done, sum_valid;
   logic        sum_ready = 1'b0;
`ifdef POSIT_ACCUM_COUNT_EN
   logic [15:0] sum_count;
`endif
   int checks = 0;
   int errors = 0;
   logic [31:0] pipe_r [4] = '{default: 32'h0};
   logic [3:0]  pipe_v = '0;

   posit_accum_es3 #(.NBITS(32), .ADD_LAT(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
      .add_result(add_result), .add_done(add_done), .sum_out(sum_out), .sum_valid(sum_valid),
      .sum_ready(sum_ready)
`ifdef POSIT_ACCUM_COUNT_EN
      , .sum_count(sum_count)
`endif
   );

   always #5 clk = ~clk;

   // decode small non-negative integer posits (es=3, regime "10"); -1 stands for NaR
   function automatic int dec(input logic [31:0] x);
      longint m;
      if (x == 32'h80000000) return -1;
      if (x == 32'h0) return 0;
      m = (longint'(1) << 26) | longint'(x[25:0]);
      return int'((m << x[28:26]) >> 26);
   endfunction

   function automatic logic [31:0] enc(input int n);
      int k;
      logic [31:0] f;
      if (n < 0) return 32'h80000000;
      if (n == 0) return 32'h0;
      k = 0;
      while ((n >> (k + 1)) != 0) k++;
      f = 32'(n - (1 << k)) << (26 - k);
      return {3'b010, 3'(k), f[25:0]};
   endfunction

   function automatic logic [31:0] padd(input logic [31:0] x, input logic [31:0] y);
      if (dec(x) < 0 || dec(y) < 0) return 32'h80000000;
      return enc(dec(x) + dec(y));
   endfunction

   always @(posedge clk) begin
      pipe_v    <= {pipe_v[2:0], add_start};
      pipe_r[0] <= padd(add_in1, add_in2);
      for (int i = 1; i < 4; i++) pipe_r[i] <= pipe_r[i-1];
   end
   assign add_done   = pipe_v[3];
   assign add_result = pipe_r[3];

   task automatic drive(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_sum(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (sum_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic take_sum();
      sum_ready = 1'b1;
      @(negedge clk);
      sum_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got %b want 0", sum_valid); end
      checks++; if (sum_out !== 32'h0) begin errors++; $display("FAIL reset_sum_out got %h want 00000000", sum_out); end
      checks++; if (add_start !== 1'b0 || add_in1 !== 32'h0 || add_in2 !== 32'h0) begin errors++; $display("FAIL reset_add got start=%b in1=%h in2=%h want 0/0/0", add_start, add_in1, add_in2); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_four();
      bit ok;
      in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b0;
      #1;
      checks++; if (add_start !== 1'b1 || add_in1 !== 32'h40000000 || add_in2 !== 32'h0) begin errors++; $display("FAIL four_issue got start=%b in1=%h in2=%h want 1/40000000/00000000", add_start, add_in1, add_in2); end
      @(negedge clk);
      drive(32'h40000000, 1'b0);
      drive(32'h40000000, 1'b0);
      drive(32'h40000000, 1'b1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL four_drain_ready got %b want 0", in_ready); end
      wait_sum(ok);
      checks++; if (!ok) begin errors++; $display("FAIL four_timeout got no sum_valid want sum_valid"); end
      checks++; if (sum_out !== 32'h48000000) begin errors++; $display("FAIL four_sum got %h want 48000000", sum_out); end
      repeat (2) @(negedge clk);
      checks++; if (sum_valid !== 1'b1 || sum_out !== 32'h48000000) begin errors++; $display("FAIL four_hold got valid=%b sum=%h want 1/48000000", sum_valid, sum_out); end
      take_sum();
      checks++; if (sum_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL four_release got valid=%b ready=%b want 0/1", sum_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 32'h40000000; in_last = (i == 7);
         #1;
         if (i == 4) begin
            checks++; if (add_in2 !== 32'h40000000) begin errors++; $display("FAIL bypass_in2 got %h want 40000000", add_in2); end
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h4C000000) begin errors++; $display("FAIL eight_sum got valid=%b sum=%h want 1/4c000000", ok, sum_out); end
`ifdef POSIT_ACCUM_COUNT_EN
      checks++; if (sum_count !== 16'd8) begin errors++; $display("FAIL eight_count got %0d want 8", sum_count); end
`endif
      take_sum();
   endtask

   task automatic test_single();
      bit ok;
      drive(32'h44000000, 1'b1);
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h44000000) begin errors++; $display("FAIL single_sum got valid=%b sum=%h want 1/44000000", ok, sum_out); end
`ifdef POSIT_ACCUM_COUNT_EN
      checks++; if (sum_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", sum_count); end
`endif
      take_sum();
   endtask

   task automatic test_nar();
      bit ok;
      drive(32'h40000000, 1'b0);
      drive(32'h80000000, 1'b0);
      drive(32'h40000000, 1'b1);
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h80000000) begin errors++; $display("FAIL nar_sum got valid=%b sum=%h want 1/80000000", ok, sum_out); end
      take_sum();
   endtask

   task automatic test_zero();
      bit ok;
      drive(32'h0, 1'b0);
      drive(32'h40000000, 1'b0);
      drive(32'h0, 1'b1);
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h40000000) begin errors++; $display("FAIL zero_sum got valid=%b sum=%h want 1/40000000", ok, sum_out); end
      take_sum();
   endtask

   task automatic test_hold();
      bit ok;
      int bad;
      drive(32'h40000000, 1'b0);
      drive(32'h40000000, 1'b1);
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h44000000) begin errors++; $display("FAIL hold_sum got valid=%b sum=%h want 1/44000000", ok, sum_out); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sum_out !== 32'h44000000 || sum_valid !== 1'b1 || in_ready !== 1'b0 || add_start !== 1'b0 || add_in1 !== 32'h0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
      take_sum();
      drive(32'h40000000, 1'b1);
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h40000000) begin errors++; $display("FAIL hold_next_sum got valid=%b sum=%h want 1/40000000", ok, sum_out); end
      take_sum();
   endtask

   task automatic test_reset_mid();
      bit ok;
      drive(32'h40000000, 1'b0);
      drive(32'h40000000, 1'b0);
      drive(32'h40000000, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (sum_valid !== 1'b0 || sum_out !== 32'h0 || add_start !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_state got valid=%b sum=%h start=%b ready=%b want 0/00000000/0/1", sum_valid, sum_out, add_start, in_ready); end
      reset = 1'b0;
      drive(32'h44000000, 1'b0);
      drive(32'h44000000, 1'b1);
      wait_sum(ok);
      checks++; if (!ok || sum_out !== 32'h48000000) begin errors++; $display("FAIL midreset_sum got valid=%b sum=%h want 1/48000000", ok, sum_out); end
      take_sum();
   endtask

   initial begin
      test_reset();
      test_four();
      test_back_to_back();
      test_single();
      test_nar();
      test_zero();
      test_hold();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
